// File: rtl/program_counter.sv
// Fetch-stage program counter: +4 per enabled cycle, hold on stall,
// PC-relative jump by a halfword-scaled immediate, synchronous reset.
module program_counter #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            jump,
    input  logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] pc_out
);

    localparam logic [XLEN-1:0] INSN_BYTES = XLEN'(4);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] offset;

    // Halfword units to bytes; the top imm bit falls off the shift.
    assign offset = {imm[XLEN-2:0], 1'b0};

    // Next PC: stall holds, jump adds the offset, otherwise step one insn.
    always_comb begin
        pc_d = pc_q;
        if (enable) begin
            if (jump) begin
                pc_d = pc_q + offset;
            end else begin
                pc_d = pc_q + INSN_BYTES;
            end
        end
    end

    // PC register; reset overrides everything on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_out = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed table,
// hand-written corner sequences and a randomized model comparison.
module tb_program_counter;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        jump;
    logic [31:0] imm;
    logic [31:0] pc_out;

    int errors = 0;
    int checks = 0;

    program_counter #(
        .XLEN(32),
        .RESET_VECTOR(32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .enable(enable),
        .jump  (jump),
        .imm   (imm),
        .pc_out(pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          en;
        bit          jmp;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] exp);
        checks++;
        if (pc_out !== exp) begin
            errors++;
            $display("FAIL %s: pc_out=%h expected=%h", name, pc_out, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, sample 1ns later.
    task automatic step(input logic r, input logic e, input logic j,
                        input logic [31:0] im);
        @(negedge clk);
        reset  = r;
        enable = e;
        jump   = j;
        imm    = im;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(bit r, bit e, bit j, logic [31:0] im,
                                logic [31:0] ex);
        vec_t v;
        v.rst = r; v.en = e; v.jmp = j; v.imm = im; v.exp = ex;
        return v;
    endfunction

    logic [31:0] model_pc;
    bit          r_r, r_e, r_j;
    logic [31:0] r_imm;

    initial begin
        reset = 1'b0; enable = 1'b0; jump = 1'b0; imm = '0;

        // Test-plan walk as a table of {inputs, expected pc}.
        vecs.push_back(mk(1, 1, 1, 32'd100, 32'h0));
        vecs.push_back(mk(1, 1, 1, 32'd100, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'd0, 32'h4));
        vecs.push_back(mk(0, 1, 0, 32'd0, 32'h8));
        vecs.push_back(mk(0, 1, 0, 32'd0, 32'hC));
        vecs.push_back(mk(0, 1, 0, 32'd0, 32'h10));
        vecs.push_back(mk(0, 0, 0, 32'd0, 32'h10));
        vecs.push_back(mk(0, 0, 1, 32'd8, 32'h10));
        vecs.push_back(mk(0, 0, 1, 32'd8, 32'h10));
        vecs.push_back(mk(0, 1, 0, 32'd0, 32'h14));
        vecs.push_back(mk(0, 1, 1, 32'd8, 32'h24));
        vecs.push_back(mk(0, 1, 1, -32'sd6, 32'h18));
        vecs.push_back(mk(0, 1, 0, 32'd0, 32'h1C));
        vecs.push_back(mk(1, 1, 1, 32'd4, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'd0, 32'h4));
        vecs.push_back(mk(0, 1, 1, 32'd1, 32'h6));
        vecs.push_back(mk(0, 1, 0, 32'd0, 32'hA));
        vecs.push_back(mk(0, 1, 1, 32'h8000_0001, 32'hC));
        vecs.push_back(mk(0, 1, 1, 32'h4000_0000, 32'h8000_000C));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].jmp, vecs[i].imm);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Wrap-around sequence.
        step(1, 0, 0, 32'd0);
        check("wrap_reset", 32'h0);
        step(0, 1, 1, -32'sd2);
        check("wrap_jump_back", 32'hFFFF_FFFC);
        step(0, 1, 0, 32'd0);
        check("wrap_increment", 32'h0);
        step(0, 1, 0, 32'd0);
        check("post_wrap_inc", 32'h4);
        step(0, 1, 1, 32'd0);
        check("self_loop", 32'h4);
        step(0, 1, 1, 32'd0);
        check("self_loop2", 32'h4);

        // Unknowns on jump/imm must be ignored when stalled or in reset.
        step(0, 0, 1'bx, 32'hxxxx_xxxx);
        check("x_stalled", 32'h4);
        step(1, 1, 1'bx, 32'hxxxx_xxxx);
        check("x_in_reset", 32'h0);
        step(0, 1, 0, 32'd0);
        check("x_recover", 32'h4);

        // Randomized run against a plain arithmetic model.
        step(1, 1, 0, 32'd0);
        check("rand_sync", 32'h0);
        model_pc = 32'h0;
        for (int n = 0; n < 400; n++) begin
            r_r   = ($urandom_range(0, 19) == 0);
            r_e   = ($urandom_range(0, 3) != 0);
            r_j   = $urandom_range(0, 1);
            r_imm = $urandom_range(0, 3) == 0 ? $urandom
                  : 32'($signed($urandom_range(0, 200)) - 100);
            if (r_r)
                model_pc = 32'h0;
            else if (!r_e)
                model_pc = model_pc;
            else if (r_j)
                model_pc = model_pc + r_imm * 2;
            else
                model_pc = model_pc + 4;
            step(r_r, r_e, r_j, r_imm);
            check($sformatf("rand%0d", n), model_pc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
